cacheline_burst_adaptor: RTL

CACHELINE_BURST_ADAPTOR -- requirements
Module: cacheline_burst_adaptor

---
 rtl/cacheline_burst_adaptor_pkg.sv | 35 +++
 rtl/line_beat_buffer.sv | 42 ++++
 rtl/cacheline_burst_adaptor.sv | 130 +++++++++++++
 3 files changed

// File: rtl/cacheline_burst_adaptor_pkg.sv
// ============================================================================
// cacheline_burst_adaptor_pkg : shared cache types for the line/burst adaptor
// Revision: 1.0
// ============================================================================
`default_nettype none

package cacheline_burst_adaptor_pkg;

   localparam int BURST_BEATS = 4;
   localparam int BEAT_WIDTH  = 64;
   localparam int LINE_WIDTH  = 256;
   localparam int BEAT_IDX_W  = 2;
   localparam int ADDR_WIDTH  = 32;
   localparam int LINE_OFFSET = 5;

   typedef enum logic [1:0] {
      BS_IDLE     = 2'd0,
      BS_RD_BURST = 2'd1,
      BS_WR_BURST = 2'd2,
      BS_DONE     = 2'd3
   } burst_state_t;

   localparam logic [1:0] ST_IDLE     = BS_IDLE;
   localparam logic [1:0] ST_RD_BURST = BS_RD_BURST;
   localparam logic [1:0] ST_WR_BURST = BS_WR_BURST;
   localparam logic [1:0] ST_DONE     = BS_DONE;

   // Cache lines are 32 bytes, so the low address bits never reach memory.
   function automatic logic [ADDR_WIDTH-1:0] align_line_addr(input logic [ADDR_WIDTH-1:0] addr);
      return {addr[ADDR_WIDTH-1:LINE_OFFSET], {LINE_OFFSET{1'b0}}};
   endfunction

endpackage

`default_nettype wire

// File: rtl/line_beat_buffer.sv
// ============================================================================
// line_beat_buffer : 4x64 line register with full-line load and beat access
// Revision: 1.0
// ============================================================================
`default_nettype none

module line_beat_buffer
   import cacheline_burst_adaptor_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [LINE_WIDTH-1:0] load_line,
   input  logic                  beat_we,
   input  logic [BEAT_IDX_W-1:0] beat_wr_idx,
   input  logic [BEAT_WIDTH-1:0] beat_wdata,
   input  logic [BEAT_IDX_W-1:0] beat_rd_idx,
   output logic [BEAT_WIDTH-1:0] beat_rdata,
   output logic [LINE_WIDTH-1:0] line_out
);

   logic [BEAT_WIDTH-1:0] beats [BURST_BEATS];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < BURST_BEATS; i++) beats[i] <= '0;
      end else if (load) begin
         for (int i = 0; i < BURST_BEATS; i++) beats[i] <= load_line[i*BEAT_WIDTH +: BEAT_WIDTH];
      end else if (beat_we) begin
         beats[beat_wr_idx] <= beat_wdata;
      end
   end

   assign beat_rdata = beats[beat_rd_idx];

   for (genvar g = 0; g < BURST_BEATS; g++) begin : g_line_out
      assign line_out[g*BEAT_WIDTH +: BEAT_WIDTH] = beats[g];
   end

endmodule

`default_nettype wire

// File: rtl/cacheline_burst_adaptor.sv
// ============================================================================
// cacheline_burst_adaptor : 256-bit cache line <-> 4-beat 64-bit memory burst.
// Optional watchdog (error_o, timeout to DONE) under macro ADAPTOR_WATCHDOG_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cacheline_burst_adaptor
   import cacheline_burst_adaptor_pkg::*;
#(
   parameter int WATCHDOG_CYCLES = 256
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [LINE_WIDTH-1:0] line_i,
   output logic [LINE_WIDTH-1:0] line_o,
   input  logic [ADDR_WIDTH-1:0] address_i,
   input  logic                  read_i,
   input  logic                  write_i,
   output logic                  resp_o,
   input  logic [BEAT_WIDTH-1:0] burst_i,
   output logic [BEAT_WIDTH-1:0] burst_o,
   output logic [ADDR_WIDTH-1:0] address_o,
   output logic                  read_o,
   output logic                  write_o,
   input  logic                  resp_i
`ifdef ADAPTOR_WATCHDOG_EN
   ,
   output logic                  error_o
`endif
);

   logic [1:0]            state;
   logic [BEAT_IDX_W-1:0] count;
   logic                  accept;
   logic                  in_burst;
   logic                  timeout;
   logic [BEAT_WIDTH-1:0] beat_rdata;
   logic [LINE_WIDTH-1:0] buf_line;

   assign accept   = (state == ST_IDLE) && (read_i || write_i);
   assign in_burst = (state == ST_RD_BURST) || (state == ST_WR_BURST);

   line_beat_buffer u_buf (
      .clk         (clk),
      .rst         (rst),
      .load        (accept),
      .load_line   (line_i),
      .beat_we     ((state == ST_RD_BURST) && resp_i),
      .beat_wr_idx (count),
      .beat_wdata  (burst_i),
      .beat_rd_idx (count),
      .beat_rdata  (beat_rdata),
      .line_out    (buf_line)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         count     <= '0;
         address_o <= '0;
         line_o    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  address_o <= align_line_addr(address_i);
                  count     <= '0;
                  state     <= read_i ? ST_RD_BURST : ST_WR_BURST;
               end
            end
            ST_RD_BURST, ST_WR_BURST: begin
               if (resp_i) begin
                  count <= count + 2'd1;
                  if (count == 2'd3) begin
                     state <= ST_DONE;
                     // Last beat is still on burst_i, so merge it while publishing the line.
                     if (state == ST_RD_BURST)
                        line_o <= {burst_i, buf_line[LINE_WIDTH-BEAT_WIDTH-1:0]};
                  end
               end else if (timeout) begin
                  state <= ST_DONE;
                  count <= '0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef ADAPTOR_WATCHDOG_EN
   localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);

   logic [WD_W-1:0] wd_cnt;
   logic            got_beat;

   // wd_cnt equals the number of burst cycles elapsed, so DONE lands WATCHDOG_CYCLES after accept.
   assign timeout = in_burst && !resp_i && !got_beat && (wd_cnt == WD_W'(WATCHDOG_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt   <= '0;
         got_beat <= 1'b0;
         error_o  <= 1'b0;
      end else if (accept) begin
         wd_cnt   <= WD_W'(1);
         got_beat <= 1'b0;
      end else if (in_burst) begin
         if (resp_i)
            got_beat <= 1'b1;
         else if (!got_beat)
            wd_cnt <= wd_cnt + WD_W'(1);
         if (timeout)
            error_o <= 1'b1;
      end
   end
`else
   localparam int unused_watchdog_cycles = WATCHDOG_CYCLES;
   assign timeout = 1'b0;
`endif

   assign resp_o  = (state == ST_DONE);
   assign read_o  = (state == ST_RD_BURST);
   assign write_o = (state == ST_WR_BURST);
   assign burst_o = (state == ST_WR_BURST) ? beat_rdata : '0;

endmodule

`default_nettype wire
